// File: rtl/alu_ctrl_muldiv.sv
// MIPS execute-stage ALU controller with an iterative multiply/divide unit.
// Decodes ALUOp/funct for the ALU and runs shift-add / restoring divide into HI/LO.
module alu_ctrl_muldiv #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [5:0]        funct_i,
    input  logic [2:0]        ALUOp_i,
    input  logic              valid_i,
    input  logic [WIDTH-1:0]  src1_i,
    input  logic [WIDTH-1:0]  src2_i,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [WIDTH-1:0]  hi_o,
    output logic [WIDTH-1:0]  lo_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 neg_q, neg_d, rem_neg_q, rem_neg_d;
    logic                 is_div_q, is_div_d, dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

    logic [3:0]           ctrl;
    logic                 is_md, is_hilo, md_req, hilo_rd;
    logic                 op_signed, s1_neg, s2_neg;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH:0]       mul_sum, div_diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod;
    logic [WIDTH-1:0]     res_hi, res_lo;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        ctrl = 4'b0010;
        unique case (ALUOp_i)
            3'd1: begin
                unique case (funct_i)
                    6'b100000: ctrl = 4'b0010;
                    6'b100010: ctrl = 4'b0110;
                    6'b100100: ctrl = 4'b0000;
                    6'b100101: ctrl = 4'b0001;
                    6'b100111: ctrl = 4'b1100;
                    6'b101010: ctrl = 4'b0111;
                    6'b000000: ctrl = 4'b1000;
                    6'b000010: ctrl = 4'b1001;
                    6'b010000: ctrl = 4'b1010;
                    6'b010010: ctrl = 4'b1011;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: ctrl = 4'b0011;
                    default:   ctrl = 4'b0010;
                endcase
            end
            3'd3:    ctrl = 4'b0111;
            3'd4:    ctrl = 4'b0110;
            3'd7:    ctrl = 4'b0100;
            default: ctrl = 4'b0010;
        endcase
    end
    assign ALUCtrl_o = CTRL_W'(ctrl);

    assign is_md   = (funct_i[5:2] == 4'b0110);
    assign is_hilo = (funct_i == 6'b010000) || (funct_i == 6'b010010);
    assign md_req  = valid_i && (ALUOp_i == 3'd1) && is_md;
    assign hilo_rd = valid_i && (ALUOp_i == 3'd1) && is_hilo;

    // funct bit 0 set selects the unsigned variants (multu/divu).
    assign op_signed = ~funct_i[0];
    assign s1_neg    = op_signed & src1_i[WIDTH-1];
    assign s2_neg    = op_signed & src2_i[WIDTH-1];
    assign mag1      = s1_neg ? -src1_i : src1_i;
    assign mag2      = s2_neg ? -src2_i : src2_i;

    // Multiply: lower half holds the remaining multiplier bits, upper half the partial product.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: upper half is the remainder, lower half shifts dividend out and quotient in.
    assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    assign div_next = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (dz_q) begin
            res_hi = acc_q[2*WIDTH-1:WIDTH];
            res_lo = acc_q[WIDTH-1:0];
        end else if (is_div_q) begin
            res_hi = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            res_lo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (md_req) begin
                    is_div_d  = funct_i[1];
                    neg_d     = s1_neg ^ s2_neg;
                    rem_neg_d = s1_neg;
                    cnt_d     = CNT_W'(WIDTH);
                    dz_d      = 1'b0;
                    if (!funct_i[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, mag2};
                        opnd_d  = mag1;
                        state_d = S_MUL;
                    end else if (src2_i == '0) begin
                        dz_d    = 1'b1;
                        acc_d   = {src1_i, {WIDTH{1'b1}}};
                        state_d = S_DONE;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, mag1};
                        opnd_d  = mag2;
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_MUL) ? mul_next : div_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            is_div_q  <= is_div_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // The final result is visible during DONE and held in hi_q/lo_q afterwards.
    assign done_o  = (state_q == S_DONE);
    assign hi_o    = done_o ? res_hi : hi_q;
    assign lo_o    = done_o ? res_lo : lo_q;
    assign stall_o = ((state_q == S_IDLE) && md_req) || (state_q == S_MUL) || (state_q == S_DIV)
                   || ((state_q == S_DONE) && (md_req || hilo_rd));

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Scoreboard bench for alu_ctrl_muldiv: decode table sweep plus directed mul/div vectors.
// Stimulus pushes expected HI/LO and completion cycle; a monitor pops on every done_o.
module tb_alu_ctrl_muldiv;
    localparam int W = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [5:0]   funct_i = '0;
    logic [2:0]   ALUOp_i = '0;
    logic         valid_i = 1'b0;
    logic [W-1:0] src1_i = '0;
    logic [W-1:0] src2_i = '0;
    logic [3:0]   ALUCtrl_o;
    logic         stall_o, done_o;
    logic [W-1:0] hi_o, lo_o;

    alu_ctrl_muldiv #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .funct_i(funct_i), .ALUOp_i(ALUOp_i),
        .valid_i(valid_i), .src1_i(src1_i), .src2_i(src2_i), .ALUCtrl_o(ALUCtrl_o),
        .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i && done_o) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", done_o, 1'b0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_hi", hi_o, mon_e.hi);
                check("sb_lo", lo_o, mon_e.lo);
                check("sb_done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic dec(input logic [2:0] op, input logic [5:0] f, input logic [3:0] exp);
        ALUOp_i = op;
        funct_i = f;
        #1;
        check($sformatf("decode_op%0d_f%b", op, f), ALUCtrl_o, exp);
    endtask

    // Present a request, wait the given number of edges for acceptance, then scramble operands.
    task automatic start_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int edges, input bit push,
                            input logic [W-1:0] eh, input logic [W-1:0] el, input int lat);
        funct_i = f;
        ALUOp_i = 3'd1;
        src1_i  = a;
        src2_i  = b;
        valid_i = 1'b1;
        repeat (edges) @(posedge clk_i);
        #1;
        if (push) sb_q.push_back('{eh, el, cyc + lat});
        valid_i = 1'b0;
        src1_i  = ~a;
        src2_i  = ~b;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        bit bad = 1'b0;
        bit got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk_i);
            if (done_o) got = 1'b1;
            else begin
                if (!stall_o) bad = 1'b1;
                n++;
            end
        end
        check({name, "_busy_stall"}, bad, 1'b0);
        check({name, "_done_seen"}, got, 1'b1);
        if (got) check({name, "_done_stall"}, stall_o, 1'b0);
    endtask

    task automatic run_md(input string name, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input int lat);
        @(negedge clk_i);
        start_md(f, a, b, 1, 1'b1, eh, el, lat);
        wait_done(name);
    endtask

    int  n;
    bit  saw_done;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_hi", hi_o, '0);
        check("rst_lo", lo_o, '0);
        check("rst_done", done_o, 1'b0);
        check("rst_stall", stall_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;

        dec(3'd0, 6'b100010, 4'b0010);
        dec(3'd1, 6'b100000, 4'b0010);
        dec(3'd1, 6'b100010, 4'b0110);
        dec(3'd1, 6'b100100, 4'b0000);
        dec(3'd1, 6'b100101, 4'b0001);
        dec(3'd1, 6'b100111, 4'b1100);
        dec(3'd1, 6'b101010, 4'b0111);
        dec(3'd1, 6'b000000, 4'b1000);
        dec(3'd1, 6'b000010, 4'b1001);
        dec(3'd1, 6'b010000, 4'b1010);
        dec(3'd1, 6'b010010, 4'b1011);
        dec(3'd1, F_MULT,    4'b0011);
        dec(3'd1, F_MULTU,   4'b0011);
        dec(3'd1, F_DIV,     4'b0011);
        dec(3'd1, F_DIVU,    4'b0011);
        dec(3'd1, 6'b111111, 4'b0010);
        dec(3'd2, 6'b100010, 4'b0010);
        dec(3'd3, 6'b100000, 4'b0111);
        dec(3'd4, 6'b100000, 4'b0110);
        dec(3'd5, 6'b100010, 4'b0010);
        dec(3'd6, 6'b100010, 4'b0010);
        dec(3'd7, 6'b100000, 4'b0100);

        run_md("mult_7_m3",   F_MULT,  32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32);
        run_md("multu_7_m3",  F_MULTU, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 32'hFFFF_FFEB, 32);
        run_md("multu_2p16",  F_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 32);
        run_md("mult_m1_m1",  F_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 32);
        run_md("divu_100_7",  F_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 32);
        run_md("div_m7_2",    F_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32);
        run_md("div_m20_m6",  F_DIV,   32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd3, 32);
        run_md("div_min_m1",  F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32);

        // mfhi issued mid-multiply must stall through DONE and then see the final HI.
        @(negedge clk_i);
        start_md(F_MULTU, 32'h8000_0000, 32'd4, 1, 1'b1, 32'd2, 32'd0, 32);
        repeat (3) @(negedge clk_i);
        funct_i  = F_MFHI;
        ALUOp_i  = 3'd1;
        valid_i  = 1'b1;
        n        = 0;
        saw_done = 1'b0;
        do begin
            @(negedge clk_i);
            if (done_o) saw_done = 1'b1;
            n++;
        end while (stall_o && n < 40);
        check("mfhi_stalled_through_done", saw_done, 1'b1);
        check("mfhi_unstalled", stall_o, 1'b0);
        check("mfhi_hi_final", hi_o, 32'd2);
        check("mfhi_ctrl", ALUCtrl_o, 4'b1010);
        valid_i = 1'b0;

        // Back-to-back: second mult presented in DONE is held and accepted in the next IDLE cycle.
        run_md("b2b_first", F_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 32);
        funct_i = F_MULT;
        ALUOp_i = 3'd1;
        src1_i  = 32'hFFFF_FFFF;
        src2_i  = 32'd2;
        valid_i = 1'b1;
        #1;
        check("b2b_stall_in_done", stall_o, 1'b1);
        start_md(F_MULT, 32'hFFFF_FFFF, 32'd2, 2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
        wait_done("b2b_second");

        run_md("div_5_by_0", F_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);

        // Reset in the middle of a divide: everything clears and no result is ever reported.
        @(negedge clk_i);
        start_md(F_DIVU, 32'd100, 32'd7, 1, 1'b0, '0, '0, 0);
        repeat (10) @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("midrst_hi", hi_o, '0);
        check("midrst_lo", lo_o, '0);
        check("midrst_done", done_o, 1'b0);
        check("midrst_stall", stall_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (40) @(negedge clk_i);
        run_md("after_rst_divu", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 32);

        @(negedge clk_i);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_muldiv.md
Name: alu_ctrl_muldiv

Overview:
- Next-generation ALU controller for the MIPS datapath, parametrised in data width.
- Decodes ALUOp_i/funct_i into ALUCtrl_o for the single-cycle ALU, as before.
- Adds an iterative multi-cycle multiply/divide unit with HI/LO registers and a stall handshake for the pipeline.
- Sits beside the ALU in the execute stage; the decoder (ALUOp) and the hazard unit (stall_o) connect to it.

Parameters:
- WIDTH, 32, operand/HI/LO width (>=4, even).
- CTRL_W, 4, ALUCtrl_o width (>=4; upper bits beyond bit 3 driven 0).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- funct_i  in  6  R-type funct field.
- ALUOp_i  in  3  main-decoder ALU op class.
- valid_i  in  1  instruction in execute stage is valid.
- src1_i  in  WIDTH  rs operand (multiplicand/dividend).
- src2_i  in  WIDTH  rt operand (multiplier/divisor).
- ALUCtrl_o  out  CTRL_W  ALU operation select (combinational).
- stall_o  out  1  hold the pipeline (combinational).
- done_o  out  1  one-cycle pulse: HI/LO just updated.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

Behaviour:
- Decode (combinational, fully specified, no latches; unlisted funct or ALUOp 0 -> 0010):
  - ALUOp 1 (R-type): add 100000->0010, sub 100010->0110, and 100100->0000, or 100101->0001, nor 100111->1100, slt 101010->0111, sll 000000->1000, srl 000010->1001, mfhi 010000->1010, mflo 010010->1011.
  - ALUOp 1, mult 011000 / multu 011001 / div 011010 / divu 011011 -> 0011 (ALU idle).
  - ALUOp 2 addi->0010; 3 slti/bge->0111; 4 branch->0110; 5 lw->0010; 6 sw->0010; 7 lui->0100.
- md_req = valid_i & ALUOp_i==1 & funct in {mult,multu,div,divu}. hilo_rd = valid_i & ALUOp_i==1 & funct in {mfhi,mflo}.
- FSM states: IDLE, MUL, DIV, DONE. Counter width clog2(WIDTH)+1.
- IDLE & md_req: latch operand magnitudes (signed ops: two's-complement abs) and result signs; counter=WIDTH; next state MUL or DIV.
- Divide by zero: skip DIV and go directly to DONE; hi=dividend (src1_i), lo=all ones.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
- DIV: restoring division, one quotient bit per cycle.
- MUL/DIV leave for DONE when the counter reaches 0 (WIDTH cycles).
- DONE (1 cycle):
  - Write hi_o/lo_o, applying sign correction. Product sign = xor of operand signs. Quotient sign = xor of signs; remainder takes the dividend's sign.
  - Assert done_o; go to IDLE.
- Latency: request accepted at edge N; done_o high during cycle N+WIDTH+1; HI/LO valid from that cycle. Divide by zero: done_o during cycle N+1.
- Signed div of INT_MIN by -1: lo=INT_MIN, hi=0 (wrap, no trap).
- stall_o = (IDLE & md_req) | MUL | DIV | (DONE & (md_req | hilo_rd)).
  - The issuing instruction is held until DONE. The pipeline must drop or retire it once stall_o falls.
  - mfhi/mflo during busy stall until HI/LO are final.
  - A new md_req in DONE is held and accepted in the following IDLE cycle.
- md_req is evaluated only in IDLE. Operand changes after acceptance are ignored.
- Reset (async, any state, including mid-operation): state=IDLE, counter=0, hi_o=0, lo_o=0, done_o=0, accumulators cleared. stall_o then follows the IDLE equation. No partial result is written.

Test Plan:
- Sweep every ALUOp 2..7, ALUOp 0, and every listed R-type funct plus an unlisted one (e.g. 111111) -> ALUCtrl_o matches the table exactly; unlisted/0 -> 0010; upper bits 0.
- mult, src1=7, src2=-3 (FFFFFFFD), WIDTH=32, accepted at edge N -> stall_o high through cycle N+32; done_o pulse during cycle N+33; hi=FFFFFFFF, lo=FFFFFFEB. multu same operands -> hi=00000006, lo=FFFFFFEB.
- divu 100/7 -> lo=14, hi=2. div -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF. div 80000000/FFFFFFFF -> lo=80000000, hi=0.
- div 5/0 -> done_o during cycle N+1; hi=5, lo=FFFFFFFF; stall_o low after DONE.
- mfhi issued during MUL -> stall_o held until DONE; first unstalled cycle sees hi_o final. Back-to-back mult in DONE -> accepted next IDLE cycle, second result correct.
- rst_i low mid-DIV (cycle 10) -> immediately hi_o=lo_o=0, done_o=0, state IDLE. No done_o pulse after release; next request completes normally.
